// File: rtl/gpio_regs_pkg.sv
// Shared constants and types for the AXI-Lite GPIO register block:
// register offsets, ID value, response codes and channel FSM states.
package gpio_regs_pkg;

  localparam logic [4:0] OFF_ID       = 5'h00;
  localparam logic [4:0] OFF_SCRATCH  = 5'h04;
  localparam logic [4:0] OFF_LED      = 5'h08;
  localparam logic [4:0] OFF_INPUT    = 5'h0C;
  localparam logic [4:0] OFF_BTN_EDGE = 5'h10;

  // Word indices as seen on addr[4:2]
  localparam logic [2:0] IDX_ID       = OFF_ID[4:2];
  localparam logic [2:0] IDX_SCRATCH  = OFF_SCRATCH[4:2];
  localparam logic [2:0] IDX_LED      = OFF_LED[4:2];
  localparam logic [2:0] IDX_INPUT    = OFF_INPUT[4:2];
  localparam logic [2:0] IDX_BTN_EDGE = OFF_BTN_EDGE[4:2];

  localparam logic [31:0] GPIO_ID = 32'h4750_494F;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/AXIL_IF.sv
// AXI-Lite bus bundle with 32-bit data; Master drives requests, Slave answers.
interface AXIL_IF #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport Master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gpio_debounce.sv
// One push button: 2-FF synchronizer followed by a stability counter.
// The counter runs while the synced input disagrees with the output; any return to agreement clears it.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic btn_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_meta;
  logic          btn_sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_db   <= 1'b0;
      cnt      <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      if (btn_sync == btn_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_db <= btn_sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_gpio_regs.sv
// AXI-Lite register slave for board GPIO: ID, scratch, LED drive, switch/button
// inputs and sticky button rising-edge flags.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); write applied when both are in
// W_RESP | bvalid high, waiting for bready
// R_IDLE | arready high, waiting for AR
// R_DATA | rvalid high with registered rdata/rresp, waiting for rready
module axil_gpio_regs
  import gpio_regs_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic        clk,
  input  logic        reset_n,
  AXIL_IF.Slave       axil_if,
  input  logic [3:0]  sw,
  input  logic [3:0]  btn,
  output logic [11:0] led_rgb,
  output logic [3:0]  led
);

  w_state_t    w_state;
  r_state_t    r_state;
  logic        rdy_en;
  logic        aw_got, w_got;
  logic [2:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic [31:0] scratch;
  logic [15:0] led_reg;
  logic [3:0]  btn_edge;
  logic [3:0]  sw_meta, sw_sync;
  logic [3:0]  btn_db, btn_db_q;

  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [15:0] led_wr;
  logic [3:0]  edge_set, edge_clr;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        addr_unused;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn[i]),
      .btn_db  (btn_db[i])
    );
  end

  // rdy_en keeps the readies low through reset and the edge that releases it
  assign axil_if.awready = rdy_en && (w_state == W_IDLE) && !aw_got;
  assign axil_if.wready  = rdy_en && (w_state == W_IDLE) && !w_got;
  assign axil_if.bvalid  = (w_state == W_RESP);
  assign axil_if.bresp   = bresp_q;
  assign axil_if.arready = rdy_en && (r_state == R_IDLE);
  assign axil_if.rvalid  = (r_state == R_DATA);
  assign axil_if.rdata   = rdata_q;
  assign axil_if.rresp   = rresp_q;

  assign led_rgb = led_reg[11:0];
  assign led     = led_reg[15:12];

  assign addr_unused = ^{axil_if.awaddr[ADDR_WIDTH-1:5], axil_if.awaddr[1:0],
                         axil_if.araddr[ADDR_WIDTH-1:5], axil_if.araddr[1:0]};

  assign aw_hs   = axil_if.awvalid && axil_if.awready;
  assign w_hs    = axil_if.wvalid  && axil_if.wready;
  assign ar_hs   = axil_if.arvalid && axil_if.arready;
  assign wr_idx  = aw_hs ? axil_if.awaddr[4:2] : aw_idx_q;
  assign wr_data = w_hs  ? axil_if.wdata : wdata_q;
  assign wr_strb = w_hs  ? axil_if.wstrb : wstrb_q;
  assign wr_fire = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);

  assign led_wr = {wr_strb[1] ? wr_data[15:8] : led_reg[15:8],
                   wr_strb[0] ? wr_data[7:0]  : led_reg[7:0]};

  // A new edge wins over a clear landing in the same cycle
  assign edge_set = btn_db & ~btn_db_q;
  assign edge_clr = (wr_fire && (wr_idx == IDX_BTN_EDGE) && wr_strb[0]) ? wr_data[3:0] : 4'b0;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (axil_if.araddr[4:2])
      IDX_ID:       rd_data = GPIO_ID;
      IDX_SCRATCH:  rd_data = scratch;
      IDX_LED:      rd_data = {16'b0, led_reg};
      IDX_INPUT:    rd_data = {24'b0, btn_db, sw_sync};
      IDX_BTN_EDGE: rd_data = {28'b0, btn_edge};
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_en   <= 1'b0;
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      scratch  <= '0;
      led_reg  <= '0;
      btn_edge <= '0;
      btn_db_q <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      rdy_en   <= 1'b1;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_db_q <= btn_db;
      btn_edge <= (btn_edge & ~edge_clr) | edge_set;

      if (w_state == W_IDLE) begin
        if (wr_fire) begin
          w_state <= W_RESP;
          aw_got  <= 1'b0;
          w_got   <= 1'b0;
          bresp_q <= (wr_idx <= IDX_BTN_EDGE) ? RESP_OKAY : RESP_SLVERR;
          if (wr_idx == IDX_SCRATCH) scratch <= apply_strb(scratch, wr_data, wr_strb);
          if (wr_idx == IDX_LED)     led_reg <= led_wr;
        end else begin
          if (aw_hs) begin
            aw_got   <= 1'b1;
            aw_idx_q <= axil_if.awaddr[4:2];
          end
          if (w_hs) begin
            w_got   <= 1'b1;
            wdata_q <= axil_if.wdata;
            wstrb_q <= axil_if.wstrb;
          end
        end
      end else if (axil_if.bready) begin
        w_state <= W_IDLE;
      end

      if (r_state == R_IDLE) begin
        if (ar_hs) begin
          rdata_q <= rd_data;
          rresp_q <= rd_resp;
          r_state <= R_DATA;
        end
      end else if (axil_if.rready) begin
        r_state <= R_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_axil_gpio_regs.sv
// Directed bench for axil_gpio_regs: a table of single register accesses plus
// hand-timed sequences for debounce, same-cycle read/write, RW1C races and reset.
module tb_axil_gpio_regs;
  import gpio_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sw = 4'h9;
  logic [3:0]  btn = 4'h0;
  logic [11:0] led_rgb;
  logic [3:0]  led;

  AXIL_IF #(.ADDR_WIDTH(32)) bus ();

  axil_gpio_regs #(.ADDR_WIDTH(32), .DEBOUNCE_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .axil_if (bus),
    .sw      (sw),
    .btn     (btn),
    .led_rgb (led_rgb),
    .led     (led)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];
  int   bounce[6] = '{3, 2, 5, 1, 6, 3};

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s, int lead,
                              logic [31:0] er, logic [1:0] resp, logic [15:0] el);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.lead = lead;
    v.exp_rdata = er; v.exp_resp = resp; v.exp_led = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] r, output int nb);
    bit aw_done = 0;
    bit w_done  = 0;
    int k = 0;
    r = 2'b11;
    nb = 0;
    bus.bready = 1'b1;
    while (!(aw_done && w_done) && k < 50) begin
      @(negedge clk);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = !aw_done && (k >= lead);
      bus.wvalid  = !w_done;
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      k++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (bus.bvalid) begin
        if (nb == 0) r = bus.bresp;
        nb++;
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat, output bit stable);
    bit hs = 0;
    int k = 0;
    d = '0;
    r = 2'b11;
    lat = -1;
    stable = 0;
    bus.rready = 1'b0;
    while (!hs && k < 50) begin
      @(negedge clk);
      bus.arvalid = 1'b1;
      bus.araddr  = a;
      hs = bus.arready;
      k++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    if (!hs) return;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      if (bus.rvalid) begin
        lat = i;
        d = bus.rdata;
        r = bus.rresp;
      end else begin
        @(negedge clk);
      end
    end
    if (lat < 0) return;
    @(negedge clk);
    stable = bus.rvalid && (bus.rdata == d) && (bus.rresp == r);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          st;
    axi_read(a, d, r, lat, st);
    check({name, " rdata"}, d, exp);
    check({name, " rresp"}, {30'b0, r}, {30'b0, RESP_OKAY});
  endtask

  task automatic wr_expect(input string name, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic [1:0] r;
    int         nb;
    axi_write(a, d, s, 0, r, nb);
    check({name, " bresp"}, {30'b0, r}, {30'b0, RESP_OKAY});
    check({name, " bvalid count"}, nb, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, nb;
    bit          st;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 1; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

    vecs.push_back(mk(0, 32'h00, 0,            4'h0, 0, GPIO_ID,      RESP_OKAY,   16'h0000));
    vecs.push_back(mk(0, 32'h04, 0,            4'h0, 0, 32'h0,        RESP_OKAY,   16'h0000));
    vecs.push_back(mk(0, 32'h08, 0,            4'h0, 0, 32'h0,        RESP_OKAY,   16'h0000));
    vecs.push_back(mk(0, 32'h10, 0,            4'h0, 0, 32'h0,        RESP_OKAY,   16'h0000));
    vecs.push_back(mk(0, 32'h0C, 0,            4'h0, 0, 32'h9,        RESP_OKAY,   16'h0000));
    vecs.push_back(mk(1, 32'h04, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        RESP_OKAY,   16'h0000));
    vecs.push_back(mk(1, 32'h04, 32'h12345678, 4'h5, 0, 32'h0,        RESP_OKAY,   16'h0000));
    vecs.push_back(mk(0, 32'h04, 0,            4'h0, 0, 32'hFF34FF78, RESP_OKAY,   16'h0000));
    vecs.push_back(mk(1, 32'h08, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        RESP_OKAY,   16'hFFFF));
    vecs.push_back(mk(0, 32'h08, 0,            4'h0, 0, 32'h0000FFFF, RESP_OKAY,   16'hFFFF));
    vecs.push_back(mk(1, 32'h08, 32'h00001234, 4'h1, 0, 32'h0,        RESP_OKAY,   16'hFF34));
    vecs.push_back(mk(0, 32'h08, 0,            4'h0, 0, 32'h0000FF34, RESP_OKAY,   16'hFF34));
    vecs.push_back(mk(1, 32'h08, 32'h0000A5F3, 4'hF, 3, 32'h0,        RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(0, 32'h08, 0,            4'h0, 0, 32'h0000A5F3, RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(0, 32'h14, 0,            4'h0, 0, 32'h0,        RESP_SLVERR, 16'hA5F3));
    vecs.push_back(mk(1, 32'h18, 32'hDEADBEEF, 4'hF, 0, 32'h0,        RESP_SLVERR, 16'hA5F3));
    vecs.push_back(mk(0, 32'h1C, 0,            4'h0, 0, 32'h0,        RESP_SLVERR, 16'hA5F3));
    vecs.push_back(mk(0, 32'h04, 0,            4'h0, 0, 32'hFF34FF78, RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(0, 32'h08, 0,            4'h0, 0, 32'h0000A5F3, RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(1, 32'h00, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(0, 32'h00, 0,            4'h0, 0, GPIO_ID,      RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(1, 32'h0C, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(0, 32'h0C, 0,            4'h0, 0, 32'h9,        RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(0, 32'h24, 0,            4'h0, 0, 32'hFF34FF78, RESP_OKAY,   16'hA5F3));
    vecs.push_back(mk(1, 32'h28, 32'hFFFF0C3C, 4'h3, 0, 32'h0,        RESP_OKAY,   16'h0C3C));
    vecs.push_back(mk(0, 32'h08, 0,            4'h0, 0, 32'h00000C3C, RESP_OKAY,   16'h0C3C));
    vecs.push_back(mk(0, 32'h10, 0,            4'h0, 0, 32'h0,        RESP_OKAY,   16'h0C3C));

    // Reset state and ready release
    repeat (3) @(negedge clk);
    check("reset awready", {31'b0, bus.awready}, 0);
    check("reset wready",  {31'b0, bus.wready},  0);
    check("reset arready", {31'b0, bus.arready}, 0);
    check("reset bvalid",  {31'b0, bus.bvalid},  0);
    check("reset rvalid",  {31'b0, bus.rvalid},  0);
    check("reset leds",    {16'b0, led, led_rgb}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset readies", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, r, nb);
        check($sformatf("v%0d bvalid count", i), nb, 1);
      end else begin
        axi_read(vecs[i].addr, d, r, lat, st);
        check($sformatf("v%0d rdata", i), d, vecs[i].exp_rdata);
        check($sformatf("v%0d read latency", i), lat, 1);
        check($sformatf("v%0d rdata stable", i), {31'b0, st}, 1);
      end
      check($sformatf("v%0d resp", i), {30'b0, r}, {30'b0, vecs[i].exp_resp});
      check($sformatf("v%0d leds", i), {16'b0, led, led_rgb}, {16'b0, vecs[i].exp_led});
    end

    // Read and write of SCRATCH handshaking on the same edge
    wr_expect("scratch pre", 32'h04, 32'h11111111, 4'hF);
    @(negedge clk);
    bus.awaddr = 32'h04; bus.awvalid = 1; bus.wdata = 32'h22222222; bus.wstrb = 4'hF; bus.wvalid = 1;
    bus.araddr = 32'h04; bus.arvalid = 1; bus.rready = 0;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    check("same-cycle rvalid", {31'b0, bus.rvalid}, 1);
    check("same-cycle old data", bus.rdata, 32'h11111111);
    check("same-cycle bvalid", {31'b0, bus.bvalid}, 1);
    bus.rready = 1;
    @(negedge clk);
    bus.rready = 0;
    rd_expect("same-cycle new data", 32'h04, 32'h22222222);

    // Button bounce shorter than the debounce window never registers
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      #1 btn[1] = (i % 2 == 0);
      repeat (bounce[i]) @(posedge clk);
    end
    #1 btn[1] = 1'b0;
    repeat (4) @(posedge clk);
    rd_expect("bounce input", 32'h0C, 32'h09);
    rd_expect("bounce edge",  32'h10, 32'h0);

    // Stable press: handshake 9 edges after the input change still sees 0, 11 edges sees 1
    @(posedge clk);
    #1 btn[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.araddr = 32'h0C; bus.arvalid = 1;
    @(posedge clk);
    #1 bus.arvalid = 0;
    @(negedge clk);
    check("debounce early rvalid", {31'b0, bus.rvalid}, 1);
    check("debounce early input", bus.rdata, 32'h09);
    bus.rready = 1;
    @(posedge clk);
    #1 bus.rready = 0; bus.arvalid = 1;
    @(posedge clk);
    #1 bus.arvalid = 0;
    @(negedge clk);
    check("debounce late rvalid", {31'b0, bus.rvalid}, 1);
    check("debounce late input", bus.rdata, 32'h29);
    bus.rready = 1;
    @(negedge clk);
    bus.rready = 0;
    rd_expect("edge set", 32'h10, 32'h2);
    wr_expect("edge clear no strb", 32'h10, 32'h2, 4'h0);
    rd_expect("edge kept", 32'h10, 32'h2);
    wr_expect("edge clear", 32'h10, 32'h2, 4'h1);
    rd_expect("edge cleared", 32'h10, 32'h0);

    // Release; the falling edge must not set the flag
    #1 btn[1] = 1'b0;
    repeat (16) @(posedge clk);
    rd_expect("release edge", 32'h10, 32'h0);

    // RW1C clear landing on the same edge as a new rising edge
    @(posedge clk);
    #1 btn[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.awaddr = 32'h10; bus.awvalid = 1; bus.wdata = 32'h2; bus.wstrb = 4'h1; bus.wvalid = 1;
    check("race readies", {30'b0, bus.awready, bus.wready}, 32'h3);
    @(posedge clk);
    #1 bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk);
    check("race bvalid", {31'b0, bus.bvalid}, 1);
    repeat (2) @(negedge clk);
    rd_expect("race edge kept", 32'h10, 32'h2);

    // Reset with a write response and a read response both pending
    @(negedge clk);
    bus.bready = 0; bus.rready = 0;
    bus.awaddr = 32'h08; bus.awvalid = 1; bus.wdata = 32'h00000FFF; bus.wstrb = 4'hF; bus.wvalid = 1;
    bus.araddr = 32'h00; bus.arvalid = 1;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    check("pre-reset bvalid", {31'b0, bus.bvalid}, 1);
    check("pre-reset rvalid", {31'b0, bus.rvalid}, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid reset bvalid", {31'b0, bus.bvalid}, 0);
    check("mid reset rvalid", {31'b0, bus.rvalid}, 0);
    check("mid reset leds", {16'b0, led, led_rgb}, 0);
    check("mid reset readies", {29'b0, bus.awready, bus.wready, bus.arready}, 0);
    reset_n = 1'b1;
    bus.bready = 1;
    @(negedge clk);
    check("re-reset readies", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);
    rd_expect("led after reset", 32'h08, 32'h0);
    rd_expect("scratch after reset", 32'h04, 32'h0);
    rd_expect("edge after reset", 32'h10, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
